// File: rtl/ctrl_pkg.sv
// Shared constants for the fetch-stage PC: default geometry, reset vector,
// the PC next-value select encoding and a constant-foldable clog2.
package ctrl_pkg;

    localparam int PROG_CTR_WID_DEF = 10;
    localparam int STACK_DEPTH_DEF  = 8;
    localparam int RESET_VEC_DEF    = 0;

    localparam logic [1:0] SEL_INC  = 2'd0;
    localparam logic [1:0] SEL_HOLD = 2'd1;
    localparam logic [1:0] SEL_TGT  = 2'd2;
    localparam logic [1:0] SEL_POP  = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ctrl_ret_stack.sv
// Circular return-address LIFO with push/pop/replace and sticky ovf/unf.
// State updates on the clock edge; a push when full overwrites the oldest entry.
module ctrl_ret_stack
    import ctrl_pkg::*;
#(
    parameter int WID   = PROG_CTR_WID_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         replace,
    input  logic [WID-1:0]               din,
    output logic [WID-1:0]               top,
    output logic [clog2(DEPTH+1)-1:0]    cnt,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WID-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, sp_m1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign sp_m1 = sp_q - PTR_ONE;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_MAX);
    assign top   = empty ? '0 : mem_q[sp_m1];
    assign cnt   = cnt_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = sp_q;
        if (replace) begin
            // Replacing on an empty stack degenerates into a plain push.
            wr_en = 1'b1;
            if (empty) begin
                sp_d  = sp_q + PTR_ONE;
                cnt_d = CNT_ONE;
            end else begin
                wr_idx = sp_m1;
            end
        end else if (push) begin
            wr_en = 1'b1;
            sp_d  = sp_q + PTR_ONE;
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CNT_ONE;
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d  = sp_m1;
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= din;
    end

endmodule

// File: rtl/ctrl_pc_ret_stack.sv
// Fetch PC with EX redirects (branch/call/return) and an integrated return stack.
// Redirects land one cycle after sampling; stall freezes sequential fetch only.
module ctrl_pc_ret_stack
    import ctrl_pkg::*;
#(
    parameter int                      PROG_CTR_WID = PROG_CTR_WID_DEF,
    parameter int                      STACK_DEPTH  = STACK_DEPTH_DEF,
    parameter logic [PROG_CTR_WID-1:0] RESET_VEC    = PROG_CTR_WID'(RESET_VEC_DEF)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              branch_taken_EX,
    input  logic                              call_EX,
    input  logic                              ret_EX,
    input  logic [PROG_CTR_WID-1:0]           nxt_prog_ctr_EX,
    input  logic [PROG_CTR_WID-1:0]           ret_addr_EX,
    output logic [PROG_CTR_WID-1:0]           prog_ctr,
    output logic [PROG_CTR_WID-1:0]           stack_top,
    output logic [clog2(STACK_DEPTH+1)-1:0]   stack_cnt,
    output logic                              stack_full,
    output logic                              stack_empty,
    output logic                              stack_ovf,
    output logic                              stack_unf
);

    localparam logic [PROG_CTR_WID-1:0] PC_ONE = PROG_CTR_WID'(1);

    logic [PROG_CTR_WID-1:0] prog_ctr_q, prog_ctr_d;
    logic [1:0]              sel;
    logic                    push, pop, replace;

    always_comb begin
        sel     = SEL_INC;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        if (call_EX && ret_EX) begin
            replace = 1'b1;
            sel     = SEL_TGT;
        end else if (call_EX) begin
            push = 1'b1;
            sel  = SEL_TGT;
        end else if (ret_EX) begin
            // An empty-stack return falls back to the EX target.
            pop = 1'b1;
            sel = stack_empty ? SEL_TGT : SEL_POP;
        end else if (branch_taken_EX) begin
            sel = SEL_TGT;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        prog_ctr_d = prog_ctr_q + PC_ONE;
        case (sel)
            SEL_HOLD: prog_ctr_d = prog_ctr_q;
            SEL_TGT:  prog_ctr_d = nxt_prog_ctr_EX;
            SEL_POP:  prog_ctr_d = stack_top;
            default:  prog_ctr_d = prog_ctr_q + PC_ONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) prog_ctr_q <= RESET_VEC;
        else       prog_ctr_q <= prog_ctr_d;
    end

    assign prog_ctr = prog_ctr_q;

    ctrl_ret_stack #(
        .WID   (PROG_CTR_WID),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .replace (replace),
        .din     (ret_addr_EX),
        .top     (stack_top),
        .cnt     (stack_cnt),
        .full    (stack_full),
        .empty   (stack_empty),
        .ovf     (stack_ovf),
        .unf     (stack_unf)
    );

endmodule

// File: tb/tb_ctrl_pc_ret_stack.sv
// Directed bench for ctrl_pc_ret_stack (W=10, DEPTH=8, RESET_VEC=0x010).
module tb_ctrl_pc_ret_stack;
    import ctrl_pkg::*;

    localparam int W     = 10;
    localparam int D     = 8;
    localparam int CNT_W = clog2(D + 1);

    logic             clk = 1'b0;
    logic             reset, stall, branch_taken_EX, call_EX, ret_EX;
    logic [W-1:0]     nxt_prog_ctr_EX, ret_addr_EX;
    logic [W-1:0]     prog_ctr, stack_top;
    logic [CNT_W-1:0] stack_cnt;
    logic             stack_full, stack_empty, stack_ovf, stack_unf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_pc_ret_stack #(
        .PROG_CTR_WID (W),
        .STACK_DEPTH  (D),
        .RESET_VEC    (10'h010)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken_EX (branch_taken_EX),
        .call_EX         (call_EX),
        .ret_EX          (ret_EX),
        .nxt_prog_ctr_EX (nxt_prog_ctr_EX),
        .ret_addr_EX     (ret_addr_EX),
        .prog_ctr        (prog_ctr),
        .stack_top       (stack_top),
        .stack_cnt       (stack_cnt),
        .stack_full      (stack_full),
        .stack_empty     (stack_empty),
        .stack_ovf       (stack_ovf),
        .stack_unf       (stack_unf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of EX inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic st, input logic br, input logic cl, input logic rt,
                       input logic [W-1:0] tgt, input logic [W-1:0] ra);
        stall = st; branch_taken_EX = br; call_EX = cl; ret_EX = rt;
        nxt_prog_ctr_EX = tgt; ret_addr_EX = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        idle();
        chk("rst_pc",    32'(prog_ctr),    32'h010);
        chk("rst_cnt",   32'(stack_cnt),   32'd0);
        chk("rst_empty", 32'(stack_empty), 32'd1);
        chk("rst_top",   32'(stack_top),   32'd0);
        chk("rst_ovf",   32'(stack_ovf),   32'd0);
        chk("rst_unf",   32'(stack_unf),   32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk("seq_pc", 32'(prog_ctr), 32'h010 + i);
        end

        // wrap-around
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF, '0);
        chk("br_3ff", 32'(prog_ctr), 32'h3FF);
        idle();
        chk("wrap_pc", 32'(prog_ctr), 32'h000);

        // stall holds, redirect overrides stall
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h005, '0);
        chk("br_005", 32'(prog_ctr), 32'h005);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("stall1", 32'(prog_ctr), 32'h005);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("stall2", 32'(prog_ctr), 32'h005);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'h200, '0);
        chk("stall_br", 32'(prog_ctr), 32'h200);
        idle();
        chk("post_br", 32'(prog_ctr), 32'h201);

        // nested call / return
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 10'h021);
        chk("call1_pc", 32'(prog_ctr), 32'h100);
        chk("call1_cnt", 32'(stack_cnt), 32'd1);
        chk("call1_top", 32'(stack_top), 32'h021);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 10'h180, 10'h105);
        chk("call2_pc", 32'(prog_ctr), 32'h180);
        chk("call2_cnt", 32'(stack_cnt), 32'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 10'h3AB, '0);
        chk("ret1_pc", 32'(prog_ctr), 32'h105);
        chk("ret1_cnt", 32'(stack_cnt), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("ret2_pc", 32'(prog_ctr), 32'h021);
        chk("ret2_cnt", 32'(stack_cnt), 32'd0);
        chk("ret2_empty", 32'(stack_empty), 32'd1);

        // overflow: 9 calls into an 8-deep stack
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, W'(10'h300 + i), W'(i));
            if (i == 8) begin
                chk("full8", 32'(stack_full), 32'd1);
                chk("noovf8", 32'(stack_ovf), 32'd0);
            end
        end
        chk("ovf_pc", 32'(prog_ctr), 32'h309);
        chk("ovf_cnt", 32'(stack_cnt), 32'd8);
        chk("ovf_full", 32'(stack_full), 32'd1);
        chk("ovf_flag", 32'(stack_ovf), 32'd1);
        chk("ovf_top", 32'(stack_top), 32'd9);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 10'h3CC, '0);
            chk("unwind_pc", 32'(prog_ctr), 32'(9 - i));
        end
        chk("unwind_empty", 32'(stack_empty), 32'd1);
        chk("unwind_unf", 32'(stack_unf), 32'd0);

        // underflow falls back to target
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 10'h0AA, '0);
        chk("unf_pc", 32'(prog_ctr), 32'h0AA);
        chk("unf_flag", 32'(stack_unf), 32'd1);
        chk("unf_cnt", 32'(stack_cnt), 32'd0);

        // call+ret replaces top
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'h123, 10'h050);
        chk("pre_rep_top", 32'(stack_top), 32'h050);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 10'h070, 10'h060);
        chk("rep_pc", 32'(prog_ctr), 32'h070);
        chk("rep_top", 32'(stack_top), 32'h060);
        chk("rep_cnt", 32'(stack_cnt), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("rep_ret_pc", 32'(prog_ctr), 32'h060);
        // call+ret on empty stack acts as push without underflow side effects
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 10'h155, 10'h0EE);
        chk("rep_empty_cnt", 32'(stack_cnt), 32'd1);
        chk("rep_empty_top", 32'(stack_top), 32'h0EE);
        chk("rep_empty_pc", 32'(prog_ctr), 32'h155);

        // mid-sequence reset
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'h1A0, 10'h011);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'h1B0, 10'h022);
        chk("pre_rst_cnt", 32'(stack_cnt), 32'd3);
        chk("pre_rst_ovf", 32'(stack_ovf), 32'd1);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'h2F0, 10'h033);
        chk("mrst_pc", 32'(prog_ctr), 32'h010);
        chk("mrst_cnt", 32'(stack_cnt), 32'd0);
        chk("mrst_ovf", 32'(stack_ovf), 32'd0);
        chk("mrst_unf", 32'(stack_unf), 32'd0);
        chk("mrst_empty", 32'(stack_empty), 32'd1);
        reset = 1'b0;
        idle();
        chk("mrst_seq", 32'(prog_ctr), 32'h011);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
